multicycle_ctrl: RTL

//  Multi-cycle sequencer for the 8-bit ALU datapath and its 3-bit-opcode ISA.

---
 rtl/multicycle_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 8-bit ALU datapath.
// Define PERF_CNT_EN to build the retired-instruction counter; otherwise retired_o is tied to 0.
module multicycle_ctrl #(
  parameter logic [7:0]  HALT_WORD = 8'hFF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             ck_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [7:0]       imem_rdata_i,
  input  logic             imem_ack_i,
  input  logic             dmem_ack_i,
  input  logic             alu_zero_i,
  output logic             imem_req_o,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic [7:0]       ir_o,
  output logic             pc_we_o,
  output logic             pc_src_o,
  output logic             alu_src_o,
  output logic             alu_op_o,
  output logic             reg_write_o,
  output logic             mem_to_reg_o,
  output logic             busy_o,
  output logic             halted_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } ctrlState_e;

  localparam logic [2:0] OpJal = 3'b000;
  localparam logic [2:0] OpJr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpBeq = 3'b011;
  localparam logic [2:0] OpSw  = 3'b100;
  localparam logic [2:0] OpLw  = 3'b101;
  localparam logic [2:0] OpXor = 3'b110;
  localparam logic [2:0] OpLa  = 3'b111;

  ctrlState_e state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic [2:0] opcode;

  assign opcode = ir_q[7:5];

  always_ff @(posedge ck_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Strobes are decoded from state, IR and the current ack, so each is a pulse within its state.
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    imem_req_o   = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    pc_we_o      = 1'b0;
    pc_src_o     = 1'b0;
    alu_src_o    = 1'b0;
    alu_op_o     = 1'b0;
    reg_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) state_d = StFetch;
      end
      StFetch: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          ir_d    = imem_rdata_i;
          state_d = StDecode;
        end
      end
      StDecode: begin
        state_d = (ir_q == HALT_WORD) ? StHalt : StExec;
      end
      StExec: begin
        case (opcode)
          OpJal: begin
            reg_write_o = 1'b1;
            pc_we_o     = 1'b1;
            pc_src_o    = 1'b1;
            state_d     = StFetch;
          end
          OpJr: begin
            pc_we_o  = 1'b1;
            pc_src_o = 1'b1;
            state_d  = StFetch;
          end
          OpAdd: begin
            alu_src_o = 1'b1;
            state_d   = StWb;
          end
          OpXor: begin
            alu_src_o = 1'b1;
            alu_op_o  = 1'b1;
            state_d   = StWb;
          end
          OpBeq: begin
            pc_we_o  = 1'b1;
            pc_src_o = alu_zero_i & ir_q[0];
            state_d  = StFetch;
          end
          default: begin
            state_d = StMem;
          end
        endcase
      end
      StMem: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = (opcode == OpSw);
        if (dmem_ack_i) begin
          if (opcode == OpSw) begin
            pc_we_o = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        reg_write_o  = 1'b1;
        pc_we_o      = 1'b1;
        mem_to_reg_o = (opcode == OpLw) || (opcode == OpLa);
        state_d      = StFetch;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign ir_o     = ir_q;
  assign state_o  = state_q;
  assign busy_o   = (state_q != StIdle) && (state_q != StHalt);
  assign halted_o = (state_q == StHalt);

`ifdef PERF_CNT_EN
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [CNT_W-1:0] retired_q;

  // Every pc_we pulse marks one retired instruction; the counter wraps naturally.
  always_ff @(posedge ck_i) begin
    if (!rst_n_i) begin
      retired_q <= '0;
    end else if (pc_we_o) begin
      retired_q <= retired_q + CntOne;
    end
  end

  assign retired_o = retired_q;
`else
  assign retired_o = '0;
`endif

endmodule
